// File: rtl/i2s_pkg.sv
// Constants shared by the I2S transmit and capture paths.
// Default slot geometry and the LRCLK word-select polarity live here.
package i2s_pkg;

  localparam int DEF_SAMPLE_WIDTH = 24;
  localparam int DEF_SLOT_WIDTH   = 32;

  typedef enum logic {
    LRCLK_LEFT  = 1'b0,
    LRCLK_RIGHT = 1'b1
  } lrclk_e;

endpackage

// File: rtl/i2s_tx_pair_fifo.sv
// Single-clock FIFO of stereo pairs with registered read data.
// Read data appears on pop_data the cycle after a pop is accepted.
module i2s_tx_pair_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                    wclk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    empty,
  output logic                    full
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   pop_data_reg;
  logic [ADDR_W-1:0]  wr_ptr_reg;
  logic [ADDR_W-1:0]  rd_ptr_reg;
  logic [LEVEL_W-1:0] level_reg;
  logic               push_ok;
  logic               pop_ok;

  assign empty    = (level_reg == '0);
  assign full     = (level_reg == LEVEL_W'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign level    = level_reg;
  assign pop_data = pop_data_reg;

  // Storage carries no reset so it maps onto RAM; reset only clears pointers.
  always_ff @(posedge wclk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
    if (pop_ok) begin
      pop_data_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LEVEL_W'(1);
        2'b01:   level_reg <= level_reg - LEVEL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S playback transmitter: buffers stereo pairs, divides wclk into BCLK/LRCLK
// and shifts each frame out MSB-first with the standard one-bit data delay.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
  parameter int BCLK_DIV     = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                         wclk,
  input  logic                         rst,
  input  logic [SAMPLE_WIDTH-1:0]      s_left,
  input  logic [SAMPLE_WIDTH-1:0]      s_right,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         i2s_bclk,
  output logic                         i2s_lrclk,
  output logic                         i2s_sdata,
  output logic                         underflow_error
);

  localparam int FRAME_WIDTH = 2 * SLOT_WIDTH;
  localparam int DIV_W       = $clog2(BCLK_DIV);
  localparam int BIT_W       = $clog2(FRAME_WIDTH);
  localparam int PAIR_WIDTH  = 2 * SAMPLE_WIDTH;

  logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   bclk_reg;
  lrclk_e                 lrclk_reg;
  logic                   sdata_reg;
  logic [FRAME_WIDTH-1:0] shift_reg;
  logic [FRAME_WIDTH-1:0] frame_word;
  logic                   running_reg;
  logic                   started_reg;
  logic                   load_pending_reg;
  logic                   underflow_reg;

  logic                   fall;
  logic                   frame_start;
  logic                   push;
  logic                   pop;
  logic [PAIR_WIDTH-1:0]  pop_data;
  logic                   fifo_empty;
  logic                   fifo_full;

  assign push = s_valid && s_ready;

  i2s_tx_pair_fifo #(
    .WIDTH (PAIR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wclk      (wclk),
    .rst       (rst),
    .push      (push),
    .push_data ({s_left, s_right}),
    .pop       (pop),
    .pop_data  (pop_data),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    fall         = (div_cnt_reg == DIV_W'(BCLK_DIV - 1));
    frame_start  = fall && (bit_cnt_reg == BIT_W'(FRAME_WIDTH - 1));
    pop          = frame_start && !fifo_empty;
    div_cnt_next = fall ? '0 : div_cnt_reg + DIV_W'(1);
    bit_cnt_next = bit_cnt_reg;
    if (fall) begin
      bit_cnt_next = frame_start ? '0 : bit_cnt_reg + BIT_W'(1);
    end
  end

  // Left sample sits at the top of the first slot, right at the top of the second.
  always_comb begin
    frame_word = '0;
    frame_word[FRAME_WIDTH-1 -: SAMPLE_WIDTH] = pop_data[PAIR_WIDTH-1 -: SAMPLE_WIDTH];
    frame_word[SLOT_WIDTH-1 -: SAMPLE_WIDTH]  = pop_data[SAMPLE_WIDTH-1:0];
  end

  always_ff @(posedge wclk) begin
    if (!rst) begin
      div_cnt_reg      <= '0;
      bit_cnt_reg      <= '0;
      bclk_reg         <= 1'b0;
      lrclk_reg        <= LRCLK_LEFT;
      sdata_reg        <= 1'b0;
      shift_reg        <= '0;
      running_reg      <= 1'b0;
      started_reg      <= 1'b0;
      load_pending_reg <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      bit_cnt_reg      <= bit_cnt_next;
      bclk_reg         <= (div_cnt_next >= DIV_W'(BCLK_DIV / 2));
      lrclk_reg        <= (bit_cnt_next >= BIT_W'(SLOT_WIDTH)) ? LRCLK_RIGHT : LRCLK_LEFT;
      running_reg      <= 1'b1;
      load_pending_reg <= pop;
      underflow_reg    <= frame_start && fifo_empty && started_reg;
      if (pop) begin
        started_reg <= 1'b1;
      end
      // At frame start the old word's LSB goes out (one-bit delay) while the
      // register is cleared; a popped pair lands one cycle later, well before
      // the next falling event since BCLK_DIV is at least 2.
      if (fall) begin
        sdata_reg <= shift_reg[FRAME_WIDTH-1];
        shift_reg <= frame_start ? '0 : (shift_reg << 1);
      end else if (load_pending_reg) begin
        shift_reg <= frame_word;
      end
    end
  end

  assign s_ready         = running_reg && !fifo_full;
  assign i2s_bclk        = bclk_reg;
  assign i2s_lrclk       = lrclk_reg;
  assign i2s_sdata       = sdata_reg;
  assign underflow_error = underflow_reg;

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Playback-direction I2S transmitter for the i2s_axi design. It accepts stereo sample pairs from the AXI side through a valid/ready handshake and buffers them in a small synchronous FIFO. It generates BCLK and LRCLK by dividing wclk and shifts samples out MSB-first in standard I2S format, with data delayed one BCLK after the LRCLK edge. It is the transmit counterpart of the capture path.

## Interface
- SAMPLE_WIDTH, 24: valid bits per channel sample.
- SLOT_WIDTH, 32: BCLK periods per channel slot. Must be ≥ SAMPLE_WIDTH.
- BCLK_DIV, 4: wclk cycles per BCLK period. Must be even and ≥ 2.
- FIFO_DEPTH, 8: stereo pairs buffered. Must be a power of 2.

Ports:
- wclk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- s_left  in  SAMPLE_WIDTH  left sample, two's complement.
- s_right  in  SAMPLE_WIDTH  right sample.
- s_valid  in  1  pair valid.
- s_ready  out  1  FIFO can accept a pair.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select: 0 = left, 1 = right.
- i2s_sdata  out  1  serial data.
- underflow_error  out  1  one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- Push: a pair is accepted on a wclk edge when s_valid=1 and s_ready=1.
- s_ready is `fifo_level < FIFO_DEPTH`, computed from the registered level. A same-cycle pop does not free space for a push in that cycle.
- div_cnt counts 0..BCLK_DIV-1 and wraps. i2s_bclk = (div_cnt ≥ BCLK_DIV/2).
- A BCLK falling event is the cycle in which div_cnt wraps to 0.
- bit_cnt counts 0..2·SLOT_WIDTH-1 and advances only on a falling event.
- i2s_lrclk = 0 while bit_cnt < SLOT_WIDTH, else 1.
- Frame start is the falling event on which bit_cnt wraps to 0. At that event:
  - If the FIFO is non-empty, pop one pair. The frame word is {left, zeros(SLOT_WIDTH-SAMPLE_WIDTH), right, zeros(SLOT_WIDTH-SAMPLE_WIDTH)}. Set `started`.
  - If the FIFO is empty, the frame word is all zero. If `started`=1, pulse underflow_error.
- I2S one-bit delay:
  - During bit_cnt = k ≥ 1, i2s_sdata = frame-word bit (2·SLOT_WIDTH − k).
  - During bit_cnt = 0, i2s_sdata = bit 0 of the previous frame word.
- i2s_sdata and i2s_lrclk change only on falling events. Receivers sample them on the BCLK rising edge.
- Pop and push in the same cycle: fifo_level is unchanged, and the popped entry is the oldest entry.
- Pop with the FIFO empty and a push in the same cycle: the pop reports underflow and the pushed pair is stored.
- Pointers wrap modulo FIFO_DEPTH. Overflow cannot occur.

## Timing
- Reset values: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, s_ready=0 (while rst=0), fifo_level=0, underflow_error=0.
- Reset state: div_cnt=0, bit_cnt=0, `started`=0, frame word zero.
- s_ready goes to 1 on the first cycle after rst returns to 1.
- The first frame start occurs 2·SLOT_WIDTH·BCLK_DIV wclk cycles after reset release. The first frame is always silent and raises no underflow.
- Push-to-fifo_level latency is 1 cycle. Pop-to-sdata latency is BCLK_DIV cycles (first left MSB at bit_cnt=1).
- Reset asserted mid-frame takes effect on the next wclk edge. FIFO contents are discarded and all outputs return to their reset values.
- underflow_error is high for exactly 1 wclk cycle per empty frame start.

## Structure
- Package i2s_pkg holds the shared constants: default SAMPLE_WIDTH/SLOT_WIDTH and the LRCLK polarity constant (LEFT=0). The capture path uses the same package.
- Sub-module i2s_tx_pair_fifo: single-clock FIFO of width 2·SAMPLE_WIDTH with push/pop/level/empty/full.
- The top level holds the dividers, bit counter, frame shift register and underflow logic.

## Test plan
Use SAMPLE_WIDTH=16, SLOT_WIDTH=16, BCLK_DIV=4, FIFO_DEPTH=4 unless stated. Sample sdata on BCLK rising edges.
1. Hold rst=0 for 5 cycles → all outputs 0 and s_ready=0. After release, s_ready=1 and i2s_bclk toggles with period 4.
2. Push left=0xA5F0, right=0x0F0F → after the silent first frame, the left slot (lrclk=0) captures 0xA5F0 and the right slot (lrclk=1) captures 0x0F0F, each MSB first, one BCLK after the lrclk edge.
3. Push 4 pairs back-to-back before any frame start → fifo_level reaches 4 and s_ready=0. A 5th valid pair is not accepted. After the next pop, fifo_level=3 and s_ready=1.
4. Play one pair, then no pushes → underflow_error pulses once at each following frame start (every 128 wclk cycles) and sdata is all 0.
5. Assert rst at bit_cnt=10 with 2 pairs queued → next cycle fifo_level=0 and bclk/lrclk/sdata=0. After release, no underflow pulses until a pair has been played.
6. With SAMPLE_WIDTH=24, SLOT_WIDTH=32, push left=0x800001 → the left slot captures 0x80000100 (bits 7..0 of the slot are zero padding).
